// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   RESULTSRC_*  : ResultSrc encodings seen in the E stage (LOAD marks a load)
//   FWD_SEL_RF   : forward select value meaning "take operand from regfile"
//   fsel_w()     : width of a forward select for a given forwarding depth
//   cnt_w()      : width of a counter able to hold 0..n
package pipe_pkg;

  localparam logic [1:0] RESULTSRC_ALU  = 2'b00;
  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;
  localparam logic [1:0] RESULTSRC_PC4  = 2'b10;

  localparam int FWD_SEL_RF = 0;

  function automatic int fsel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   master : datapath side, drives pipeline register fields, receives controls
//   slave  : hazard controller side
// Field names follow the datapath's pipeline-register naming (xxxD / xxxE).
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int MC_SLOTS  = 4,
  parameter int PERF_W    = 16
);
  import pipe_pkg::*;

  localparam int FSEL_W = fsel_w(FWD_DEPTH);
  localparam int CNT_W  = cnt_w(MC_SLOTS);

  logic [REG_AW-1:0]           Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic                        LoadE;
  logic [FWD_DEPTH*REG_AW-1:0] RdFwd;
  logic [FWD_DEPTH-1:0]        RegWriteFwd;
  logic                        PCSrcE, JalrE;
  logic                        McIssueE, McUseD, McDone;
  logic [REG_AW-1:0]           McRd;

  logic                        StallF, StallD, FlushD, FlushE;
  logic [FSEL_W-1:0]           ForwardAE, ForwardBE;
  logic [CNT_W-1:0]            McPending;
  logic [PERF_W-1:0]           StallCycles;
  logic                        McErr;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, LoadE, RdFwd, RegWriteFwd,
           PCSrcE, JalrE, McIssueE, McUseD, McDone, McRd,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           McPending, StallCycles, McErr
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, LoadE, RdFwd, RegWriteFwd,
           PCSrcE, JalrE, McIssueE, McUseD, McDone, McRd,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           McPending, StallCycles, McErr
  );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Pending-destination scoreboard for the out-of-order multi-cycle unit.
//   clk, reset     : clock, async active-low reset
//   issue/issue_rd : op launched from E, destination register
//   done/done_rd   : op write-back, destination register
//   pend           : one bit per architectural register, x0 never set
//   pend_cnt       : outstanding op count
//   err            : sticky, a write-back arrived for a non-pending register
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int MC_SLOTS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue,
  input  logic [REG_AW-1:0]           issue_rd,
  input  logic                        done,
  input  logic [REG_AW-1:0]           done_rd,
  output logic [(1<<REG_AW)-1:0]      pend,
  output logic [$clog2(MC_SLOTS+1)-1:0] pend_cnt,
  output logic                        err
);

  logic inc, dec;

  assign inc = issue && (issue_rd != '0);
  assign dec = done && pend[done_rd];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      pend_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (done) pend[done_rd] <= 1'b0;
      // Set after clear: a reissue to a completing register stays pending.
      if (inc) pend[issue_rd] <= 1'b1;
      if (inc && !dec && pend_cnt != '1)
        pend_cnt <= pend_cnt + 1'b1;
      else if (dec && !inc && pend_cnt != '0)
        pend_cnt <= pend_cnt - 1'b1;
      if (done && !pend[done_rd]) err <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / forwarding controller for the 5-stage RV32 pipeline.
//   clk    : rising-edge clock
//   reset  : async active-low reset
//   bus    : pipeline fields in, stall/flush/forward controls and status out
// Forward selects: 0 = regfile, k+1 = nearest writing stage k after E.
// Redirect (taken branch / jalr) overrides any stall since D is discarded.
module pipe_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int MC_SLOTS  = 4,
  parameter int PERF_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_hazard_ctrl_if.slave bus
);
  import pipe_pkg::*;

  localparam int FSEL_W = fsel_w(FWD_DEPTH);
  localparam int CNT_W  = cnt_w(MC_SLOTS);

  logic [(1<<REG_AW)-1:0] pend;
  logic [CNT_W-1:0]       pend_cnt;
  logic                   mc_err;

  hazard_scoreboard #(.REG_AW(REG_AW), .MC_SLOTS(MC_SLOTS)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .issue    (bus.McIssueE),
    .issue_rd (bus.RdE),
    .done     (bus.McDone),
    .done_rd  (bus.McRd),
    .pend     (pend),
    .pend_cnt (pend_cnt),
    .err      (mc_err)
  );

  assign bus.McPending = pend_cnt;
  assign bus.McErr     = mc_err;

  // Forwarding
  logic [FWD_DEPTH-1:0] hit_a, hit_b;
  logic [FSEL_W-1:0]    fwd_a, fwd_b;

  for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_fwd
    logic [REG_AW-1:0] rd_k;
    assign rd_k     = bus.RdFwd[k*REG_AW +: REG_AW];
    assign hit_a[k] = bus.RegWriteFwd[k] && (rd_k == bus.Rs1E) && (bus.Rs1E != '0);
    assign hit_b[k] = bus.RegWriteFwd[k] && (rd_k == bus.Rs2E) && (bus.Rs2E != '0);
  end

  // Scan from the oldest stage down so the youngest matching stage wins.
  always_comb begin
    fwd_a = FSEL_W'(FWD_SEL_RF);
    fwd_b = FSEL_W'(FWD_SEL_RF);
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (hit_a[i]) fwd_a = FSEL_W'(i + 1);
      if (hit_b[i]) fwd_b = FSEL_W'(i + 1);
    end
  end

  assign bus.ForwardAE = fwd_a;
  assign bus.ForwardBE = fwd_b;

  // Stall / flush
  logic        load_use, sb_hit1, sb_hit2, slot_full, stall_req, redir;
  logic        issue_ok, done_valid;
  logic [31:0] slot_sum, slot_lim;

  assign load_use = bus.LoadE && (bus.RdE != '0) &&
                    ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

  // A register completing this cycle reaches D through the regfile bypass.
  assign sb_hit1 = (bus.Rs1D != '0) && pend[bus.Rs1D] &&
                   !(bus.McDone && (bus.McRd == bus.Rs1D));
  assign sb_hit2 = (bus.Rs2D != '0) && pend[bus.Rs2D] &&
                   !(bus.McDone && (bus.McRd == bus.Rs2D));

  assign issue_ok   = bus.McIssueE && (bus.RdE != '0);
  assign done_valid = bus.McDone && pend[bus.McRd];

  // Projected occupancy compared as sum >= limit + retire to avoid underflow.
  assign slot_sum  = 32'(pend_cnt) + 32'(issue_ok);
  assign slot_lim  = 32'(MC_SLOTS) + 32'(done_valid);
  assign slot_full = bus.McUseD && (slot_sum >= slot_lim);

  assign stall_req = load_use | sb_hit1 | sb_hit2 | slot_full;
  assign redir     = bus.PCSrcE | bus.JalrE;

  assign bus.StallF = !redir && stall_req;
  assign bus.StallD = !redir && stall_req;
  assign bus.FlushD = redir;
  assign bus.FlushE = redir | stall_req;

  // Stall-cycle perf counter, saturating
  logic [PERF_W-1:0] stall_cycles;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cycles <= '0;
    else if (bus.StallD && stall_cycles != '1)
      stall_cycles <= stall_cycles + 1'b1;
  end

  assign bus.StallCycles = stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected outputs are queued when each
// step's inputs are applied and checked mid-cycle against the DUT.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW    = 5;
  localparam int FWD_DEPTH = 2;
  localparam int MC_SLOTS  = 2;
  localparam int PERF_W    = 3;
  localparam int CYC_MAX   = 7;

  logic clk;
  logic reset;

  pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH),
                        .MC_SLOTS(MC_SLOTS), .PERF_W(PERF_W)) bus ();

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH),
                     .MC_SLOTS(MC_SLOTS), .PERF_W(PERF_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       sf, sd, fd, fe;
    logic [1:0] fa, fb;
    logic [1:0] pc;
    logic [2:0] cyc;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cyc = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic sf, input logic sd,
                      input logic fd, input logic fe, input logic [1:0] fa,
                      input logic [1:0] fb, input logic [1:0] pc, input logic err);
    exp_t e;
    e.tag = tag; e.sf = sf; e.sd = sd; e.fd = fd; e.fe = fe;
    e.fa = fa; e.fb = fb; e.pc = pc; e.cyc = 3'(exp_cyc); e.err = err;
    q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $error("FAIL queue_empty observed=0 expected=1");
      return;
    end
    e = q.pop_front();
    cmp({e.tag, ".StallF"},      32'(bus.StallF),      32'(e.sf));
    cmp({e.tag, ".StallD"},      32'(bus.StallD),      32'(e.sd));
    cmp({e.tag, ".FlushD"},      32'(bus.FlushD),      32'(e.fd));
    cmp({e.tag, ".FlushE"},      32'(bus.FlushE),      32'(e.fe));
    cmp({e.tag, ".ForwardAE"},   32'(bus.ForwardAE),   32'(e.fa));
    cmp({e.tag, ".ForwardBE"},   32'(bus.ForwardBE),   32'(e.fb));
    cmp({e.tag, ".McPending"},   32'(bus.McPending),   32'(e.pc));
    cmp({e.tag, ".StallCycles"}, 32'(bus.StallCycles), 32'(e.cyc));
    cmp({e.tag, ".McErr"},       32'(bus.McErr),       32'(e.err));
  endtask

  // Inputs are applied just after a rising edge; outputs checked on the falling edge.
  task automatic step(input string tag, input logic sf, input logic sd,
                      input logic fd, input logic fe, input logic [1:0] fa,
                      input logic [1:0] fb, input logic [1:0] pc, input logic err);
    push(tag, sf, sd, fd, fe, fa, fb, pc, err);
    @(negedge clk);
    check_pop();
    @(posedge clk);
    if (sd && exp_cyc < CYC_MAX) exp_cyc++;
    #1;
  endtask

  task automatic idle();
    bus.Rs1D = '0; bus.Rs2D = '0; bus.Rs1E = '0; bus.Rs2E = '0; bus.RdE = '0;
    bus.LoadE = 1'b0; bus.RdFwd = '0; bus.RegWriteFwd = '0;
    bus.PCSrcE = 1'b0; bus.JalrE = 1'b0;
    bus.McIssueE = 1'b0; bus.McUseD = 1'b0; bus.McDone = 1'b0; bus.McRd = '0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle();
    #3;
    push("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    check_pop();
    @(posedge clk); #1;
    reset = 1'b1;

    step("idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // Forwarding
    idle(); bus.RegWriteFwd = 2'b11; bus.RdFwd = {5'd5, 5'd5}; bus.Rs1E = 5'd5;
    step("fwd_m_wins", 0, 0, 0, 0, 1, 0, 0, 0);
    bus.RegWriteFwd = 2'b10;
    step("fwd_w_only", 0, 0, 0, 0, 2, 0, 0, 0);
    bus.Rs1E = 5'd0; bus.Rs2E = 5'd5;
    step("fwd_x0", 0, 0, 0, 0, 0, 2, 0, 0);
    idle(); bus.RegWriteFwd = 2'b11; bus.RdFwd = {5'd4, 5'd3}; bus.Rs1E = 5'd4; bus.Rs2E = 5'd3;
    step("fwd_split", 0, 0, 0, 0, 2, 1, 0, 0);

    // Load-use
    idle(); bus.LoadE = 1'b1; bus.RdE = 5'd7; bus.Rs2D = 5'd7;
    step("load_use", 1, 1, 0, 1, 0, 0, 0, 0);
    bus.LoadE = 1'b0;
    step("load_gone", 0, 0, 0, 0, 0, 0, 0, 0);

    // Redirect over stall
    bus.LoadE = 1'b1; bus.JalrE = 1'b1;
    step("jalr_over_stall", 0, 0, 1, 1, 0, 0, 0, 0);
    idle(); bus.PCSrcE = 1'b1;
    step("branch_taken", 0, 0, 1, 1, 0, 0, 0, 0);
    idle(); bus.LoadE = 1'b1;
    step("load_rd_x0", 0, 0, 0, 0, 0, 0, 0, 0);

    // Scoreboard hold until completion
    idle(); bus.McIssueE = 1'b1; bus.RdE = 5'd9;
    step("issue_x9", 0, 0, 0, 0, 0, 0, 0, 0);
    idle(); bus.Rs1D = 5'd9;
    for (int i = 0; i < 3; i++) step("sb_hold", 1, 1, 0, 1, 0, 0, 1, 0);
    bus.McDone = 1'b1; bus.McRd = 5'd9;
    step("sb_done", 0, 0, 0, 0, 0, 0, 1, 0);
    bus.McDone = 1'b0;
    step("sb_clear", 0, 0, 0, 0, 0, 0, 0, 0);

    // Slot limit
    idle(); bus.McIssueE = 1'b1; bus.RdE = 5'd3;
    step("issue_x3", 0, 0, 0, 0, 0, 0, 0, 0);
    bus.RdE = 5'd4;
    step("issue_x4", 0, 0, 0, 0, 0, 0, 1, 0);
    idle(); bus.McUseD = 1'b1;
    step("slot_full", 1, 1, 0, 1, 0, 0, 2, 0);
    bus.McDone = 1'b1; bus.McRd = 5'd3;
    step("slot_retire", 0, 0, 0, 0, 0, 0, 2, 0);
    idle(); bus.McDone = 1'b1; bus.McRd = 5'd4;
    step("done_x4", 0, 0, 0, 0, 0, 0, 1, 0);

    // Issue and done on the same register
    idle(); bus.McIssueE = 1'b1; bus.RdE = 5'd6;
    step("issue_x6", 0, 0, 0, 0, 0, 0, 0, 0);
    bus.McDone = 1'b1; bus.McRd = 5'd6;
    step("issue_done_x6", 0, 0, 0, 0, 0, 0, 1, 0);
    idle(); bus.Rs1D = 5'd6;
    step("x6_still_pend", 1, 1, 0, 1, 0, 0, 1, 0);
    idle(); bus.McDone = 1'b1; bus.McRd = 5'd6;
    step("done_x6", 0, 0, 0, 0, 0, 0, 1, 0);

    // Completion for a non-pending register
    idle(); bus.McDone = 1'b1; bus.McRd = 5'd10;
    step("done_unpend", 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step("err_sticky", 0, 0, 0, 0, 0, 0, 0, 1);

    // Perf counter saturation
    bus.LoadE = 1'b1; bus.RdE = 5'd7; bus.Rs1D = 5'd7;
    for (int i = 0; i < 3; i++) step("sat_stall", 1, 1, 0, 1, 0, 0, 0, 1);
    idle();
    step("sat_hold", 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset in the middle of a scoreboard stall
    bus.McIssueE = 1'b1; bus.RdE = 5'd12;
    step("issue_x12", 0, 0, 0, 0, 0, 0, 0, 1);
    idle(); bus.Rs1D = 5'd12;
    push("pre_reset_stall", 1, 1, 0, 1, 0, 0, 1, 1);
    @(negedge clk);
    check_pop();
    #2 reset = 1'b0;
    #1;
    exp_cyc = 0;
    push("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    check_pop();
    #1 reset = 1'b1;
    @(posedge clk); #1;
    step("after_reset", 0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
